wash_phase_timer: RTL and testbench
===================================

// Module: wash_phase_timer
// PURPOSE
//  Phase countdown timer serving the washing-machine controller FSM.
//  - Consumes the FSM's timer_start/timer_value load request; returns a one-cycle timer_done.
//  - Supports freeze (pause), abort, remaining-time readback and an agitation-direction square wave.
//  - Sits between the controller FSM and the prescaled system clock domain (same clock).
// PARAMETERS
//  WIDTH     32  width of timer_value, remaining and the elapsed-tick counter
//  PRESCALE  1   clk cycles per count tick (>=1); 1 = count every cycle
//  DIR_BIT   20  elapsed-tick bit driving agitate_dir (< WIDTH)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high reset
//  timer_start  in   1      load pulse; samples timer_value on same edge
//  timer_value  in   WIDTH  phase duration in ticks
//  hold         in   1      level; freezes count while high (machine paused)
//  abort        in   1      level/pulse; cancels phase, no timer_done
//  timer_done   out  1      registered 1-cycle pulse at phase expiry
//  busy         out  1      high in RUN or PAUSED
//  remaining    out  WIDTH  ticks left in current phase
//  agitate_dir  out  1      elapsed[DIR_BIT]; 0/1 selects motor direction
// BEHAVIOUR
//  Reset: state=IDLE; timer_done, busy, remaining, agitate_dir, elapsed, prescaler all 0.
//  States: IDLE, RUN, PAUSED. busy = (state != IDLE), registered.
//  Per-edge priority: reset > abort > timer_start > hold > tick.
//  - abort: state=IDLE, remaining=0, elapsed=0, prescaler=0, timer_done=0.
//  - timer_start (any state): remaining=timer_value, elapsed=0, prescaler=0.
//    - value==0: state=IDLE, timer_done=1 on the next cycle.
//    - else: state=PAUSED if hold is high, else RUN.
//    - A reload during RUN/PAUSED discards the old phase; no done for it.
//  - RUN and hold: go to PAUSED. Prescaler, remaining and elapsed are kept.
//  - PAUSED and !hold: go to RUN and resume counting from the kept prescaler value.
//  - RUN tick: prescaler counts 0..PRESCALE-1; a tick is the edge where prescaler==PRESCALE-1.
//    - On a tick: prescaler=0, remaining-=1, elapsed+=1.
//    - elapsed wraps mod 2^WIDTH.
//  - Expiry: the tick that takes remaining 1->0 also sets state=IDLE and timer_done=1.
//  Timing:
//    - Load at edge E0 with value N>0, no hold: timer_done is visible after edge E(N*PRESCALE) for exactly 1 cycle.
//    - remaining==0 is visible in the same cycle as timer_done.
//    - Time spent in PAUSED extends the phase cycle-for-cycle.
//  Pulse rules:
//    - timer_done is cleared on every edge where it is not being set.
//    - timer_done never asserts in PAUSED or after abort.
//  Idle behaviour:
//    - hold in IDLE has no effect.
//    - remaining never underflows; it stays 0 in IDLE.
//  agitate_dir = elapsed[DIR_BIT], registered. It holds its value in PAUSED and returns to 0 on load/abort.
// TESTING
//  1. PRESCALE=1, start with value=5 -> remaining 5,4,3,2,1,0; done high exactly 5 cycles after load edge, 1 cycle wide; busy falls with done.
//  2. Start with value=0 -> done=1 the next cycle, busy stays 0, remaining=0.
//  3. value=10, hold 4 cycles at remaining=6 -> remaining frozen at 6, busy=1, no done; done arrives 14 cycles after load.
//  4. value=10, abort at remaining=3 -> IDLE, remaining=0, busy=0, no done pulse ever.
//  5. value=10, reload with 3 at remaining=4 -> single done 3 cycles after reload; start+abort same edge -> abort wins.
//  6. PRESCALE=4, DIR_BIT=1, value=8 -> remaining decrements every 4 cycles; agitate_dir toggles every 2 ticks; done at cycle 32.

Source files
------------

// File: rtl/wash_phase_timer.sv
// Phase countdown timer for the washing-machine controller: load, pause, abort,
// remaining-time readback and an agitation-direction square wave from elapsed ticks.
//
// state  | meaning
// IDLE   | no phase active, remaining held at 0
// RUN    | counting prescaled ticks down toward expiry
// PAUSED | phase frozen by hold; prescaler/remaining/elapsed kept
module wash_phase_timer #(
   parameter int WIDTH    = 32,
   parameter int PRESCALE = 1,
   parameter int DIR_BIT  = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             timer_start,
   input  logic [WIDTH-1:0] timer_value,
   input  logic             hold,
   input  logic             abort,
   output logic             timer_done,
   output logic             busy,
   output logic [WIDTH-1:0] remaining,
   output logic             agitate_dir
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t           state;
   logic [PW-1:0]    prescaler;
   logic [WIDTH-1:0] elapsed;
   logic [WIDTH-1:0] elapsed_inc;
   logic             tick;

   assign elapsed_inc = elapsed + WIDTH'(1);
   assign tick        = (prescaler == PW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         prescaler   <= '0;
         elapsed     <= '0;
         remaining   <= '0;
         timer_done  <= 1'b0;
         busy        <= 1'b0;
         agitate_dir <= 1'b0;
      end else begin
         timer_done <= 1'b0;
         if (abort) begin
            state       <= IDLE;
            prescaler   <= '0;
            elapsed     <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            agitate_dir <= 1'b0;
         end else if (timer_start) begin
            prescaler   <= '0;
            elapsed     <= '0;
            remaining   <= timer_value;
            agitate_dir <= 1'b0;
            if (timer_value == '0) begin
               state      <= IDLE;
               busy       <= 1'b0;
               timer_done <= 1'b1;
            end else begin
               state <= hold ? PAUSED : RUN;
               busy  <= 1'b1;
            end
         end else begin
            case (state)
               RUN, PAUSED: begin
                  if (hold) begin
                     state <= PAUSED;
                  end else begin
                     // The un-pausing edge counts too, so a pause costs exactly its own length.
                     state <= RUN;
                     if (tick) begin
                        prescaler   <= '0;
                        remaining   <= remaining - WIDTH'(1);
                        elapsed     <= elapsed_inc;
                        agitate_dir <= elapsed_inc[DIR_BIT];
                        if (remaining == WIDTH'(1)) begin
                           state      <= IDLE;
                           busy       <= 1'b0;
                           timer_done <= 1'b1;
                        end
                     end else begin
                        prescaler <= prescaler + PW'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: two instances (PRESCALE 1 and 4) share
// stimulus; a cycle-counting reference model predicts outputs after each edge.
module tb_wash_phase_timer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          timer_start = 1'b0;
   logic [W-1:0]  timer_value = '0;
   logic          hold = 1'b0;
   logic          abort = 1'b0;

   logic          done0, busy0, dir0;
   logic [W-1:0]  rem0;
   logic          done1, busy1, dir1;
   logic [W-1:0]  rem1;

   always #5 clk = ~clk;

   wash_phase_timer #(.WIDTH(W), .PRESCALE(1), .DIR_BIT(2)) dut0 (
      .clk(clk), .reset(reset), .timer_start(timer_start), .timer_value(timer_value),
      .hold(hold), .abort(abort), .timer_done(done0), .busy(busy0),
      .remaining(rem0), .agitate_dir(dir0));

   wash_phase_timer #(.WIDTH(W), .PRESCALE(4), .DIR_BIT(1)) dut1 (
      .clk(clk), .reset(reset), .timer_start(timer_start), .timer_value(timer_value),
      .hold(hold), .abort(abort), .timer_done(done1), .busy(busy1),
      .remaining(rem1), .agitate_dir(dir1));

   typedef struct packed {
      logic         done;
      logic         busy;
      logic [W-1:0] rem;
      logic         dir;
   } out_t;

   typedef struct packed {
      out_t e0;
      out_t e1;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: a phase of n ticks lasts n*P non-held edges after the load edge.
   int unsigned mp[2]   = '{1, 4};
   int unsigned md[2]   = '{2, 1};
   bit          act[2]  = '{0, 0};
   int unsigned n[2]    = '{0, 0};
   int unsigned cnt[2]  = '{0, 0};
   int unsigned ticks[2] = '{0, 0};

   function automatic out_t model_step(input int d, input bit r, input bit a, input bit s,
                                       input int unsigned v, input bit h);
      out_t o;
      bit dn = 1'b0;
      if (r || a) begin
         act[d] = 0; n[d] = 0; cnt[d] = 0; ticks[d] = 0;
      end else if (s) begin
         n[d] = v; cnt[d] = 0; ticks[d] = 0;
         act[d] = (v != 0);
         dn = (v == 0);
      end else if (act[d] && !h) begin
         cnt[d]++;
         ticks[d] = cnt[d] / mp[d];
         if (cnt[d] == n[d] * mp[d]) begin
            act[d] = 0;
            dn = 1'b1;
         end
      end
      o.done = dn;
      o.busy = act[d];
      o.rem  = act[d] ? W'(n[d] - cnt[d] / mp[d]) : '0;
      o.dir  = (ticks[d] >> md[d]) & 1;
      return o;
   endfunction

   task automatic cyc(input bit r, input bit a, input bit s, input int unsigned v, input bit h);
      exp_t e;
      @(negedge clk);
      reset = r; abort = a; timer_start = s; timer_value = W'(v); hold = h;
      e.e0 = model_step(0, r, a, s, v, h);
      e.e1 = model_step(1, r, a, s, v, h);
      q.push_back(e);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
   endtask

   // Monitor: every edge the DUTs present fresh outputs; pop and compare.
   always @(posedge clk) begin
      exp_t e;
      out_t a0, a1;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         a0 = '{done: done0, busy: busy0, rem: rem0, dir: dir0};
         a1 = '{done: done1, busy: busy1, rem: rem1, dir: dir1};
         vectors += 2;
         if (a0 !== e.e0) begin
            miscompares++;
            $display("FAIL dut0 t=%0t got done=%b busy=%b rem=%0d dir=%b, want done=%b busy=%b rem=%0d dir=%b",
                     $time, a0.done, a0.busy, a0.rem, a0.dir, e.e0.done, e.e0.busy, e.e0.rem, e.e0.dir);
         end
         if (a1 !== e.e1) begin
            miscompares++;
            $display("FAIL dut1 t=%0t got done=%b busy=%b rem=%0d dir=%b, want done=%b busy=%b rem=%0d dir=%b",
                     $time, a1.done, a1.busy, a1.rem, a1.dir, e.e1.done, e.e1.busy, e.e1.rem, e.e1.dir);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit s, h, a, r;
      int unsigned v;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      idle(2);
      // Plain countdown of 5, then a zero-length phase.
      cyc(0, 0, 1, 5, 0); idle(25);
      cyc(0, 0, 1, 0, 0); idle(3);
      // Hold in IDLE is a no-op.
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      // Pause for 4 edges at remaining 6.
      cyc(0, 0, 1, 10, 0); idle(4);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      idle(50);
      // Abort mid-phase.
      cyc(0, 0, 1, 10, 0); idle(7);
      cyc(0, 1, 0, 0, 0); idle(15);
      // Reload mid-phase, then start and abort on the same edge.
      cyc(0, 0, 1, 10, 0); idle(6);
      cyc(0, 0, 1, 3, 0); idle(15);
      cyc(0, 0, 1, 9, 0); idle(2);
      cyc(0, 1, 1, 7, 0); idle(5);
      // Load while hold is high starts paused.
      cyc(0, 0, 1, 4, 1); cyc(0, 0, 0, 0, 1); idle(20);
      // Longer phase to exercise agitation direction on the prescaled instance.
      cyc(0, 0, 1, 8, 0); idle(40);
      h = 0;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 29) == 0);
         v = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) h = !h;
         a = ($urandom_range(0, 79) == 0);
         r = ($urandom_range(0, 599) == 0);
         cyc(r, a, s, v, h);
      end
      idle(3);
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
